crc16_frame_ctrl: RTL
=====================

Name: crc16_frame_ctrl

Overview:
- Frame-level sequencer for the bit-serial Modbus CRC-16 engine (poly 0xA001, init 0xFFFF, 8 shift cycles per byte, crc_ready when done).
- Sits between the UART byte stream and the downstream byte sink.
- Re-initialises the engine at each frame start, then feeds it one byte at a time while passing bytes through.
- TX mode: appends the 2-byte CRC, low byte first. RX mode: checks the received frame's residual and flags pass/fail.

Parameters:
- MAX_LEN, 256: maximum input bytes per frame, CRC bytes included in RX mode.
- LEN_W, 9: width of the byte counter; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- tx_mode  in  1  1 = generate and append CRC, 0 = check CRC; sampled in IDLE at frame start
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid && s_ready
- s_data  in  8  input byte
- s_last  in  1  marks the final input byte of the frame
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accept
- m_data  out  8  output byte
- m_last  out  1  final output byte of the frame
- crc_rst_n  out  1  engine synchronous reset, active-low
- crc_en  out  1  engine byte-load strobe
- crc_data  out  8  engine data_in
- crc_reg  in  16  engine CRC register
- crc_ready  in  1  engine done flag
- frame_done  out  1  one-cycle pulse at frame end
- crc_ok  out  1  RX: residual == 0 and length >= 3; valid with frame_done
- crc_err  out  1  RX residual != 0, RX short frame, or overlength; valid with frame_done
- crc_value  out  16  final crc_reg of the frame; held until the next frame_done

Behaviour:
- Reset values: all outputs 0 except crc_rst_n = 1. State = IDLE, counters 0.
- IDLE: s_ready = 0. On s_valid, latch tx_mode and go to INIT. The byte is not consumed.
- INIT: one cycle, crc_rst_n = 0, engine reloads 0xFFFF. Clear byte count. Go to GET.
- GET: s_ready = 1. On handshake, capture s_data/s_last into a hold register, increment count, go to FEED.
- FEED: one cycle, crc_en = 1, crc_data = hold byte. Go to XFER.
- XFER: m_valid = 1, m_data = hold byte.
  - m_last = hold_last && !tx_mode.
  - Wait until the byte is accepted (m_ready sampled while m_valid = 1) and crc_ready = 1. These may occur in either order; a flag remembers the m handshake.
  - crc_ready is only honoured from the second XFER cycle, because the engine clears it at the crc_en edge.
  - Exit: not last -> GET; last && tx_mode -> APP_LO; last && !tx_mode -> CHECK.
- Minimum per-byte latency, handshake to next s_ready: 11 cycles (FEED 1 + 8 shifts + ready 1 + GET 1).
- APP_LO: m_valid = 1, m_data = crc_reg[7:0], m_last = 0. Hold until m_ready, then APP_HI.
- APP_HI: m_data = crc_reg[15:8], m_last = 1. On m_ready go to DONE.
- CHECK: one cycle. Compute crc_ok / crc_err. Go to DONE.
- DONE: one cycle.
  - frame_done = 1; crc_ok / crc_err valid this cycle only.
  - crc_value <= crc_reg.
  - TX mode: crc_ok = crc_err = 0. Return to IDLE.
- Overlength: if count reaches MAX_LEN and that byte is not last:
  - Stop feeding the engine and drop the remaining bytes (s_ready = 1) through s_last.
  - DONE with crc_err = 1 in both modes; TX emits no CRC bytes.
- Boundaries:
  - A single-byte TX frame is legal.
  - An RX frame with count < 3 gives crc_err regardless of residual.
  - s_valid arriving in any state other than GET (or a drop) is ignored; no handshake occurs.
  - tx_mode changes mid-frame have no effect.
- rst_n asserted mid-frame aborts immediately: no frame_done, outputs return to reset values. The engine is re-initialised by INIT of the next frame.

Optional Feature:
- Macro: CRC16_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [15:0], reset 0.
  - Increments on every frame_done with crc_err = 1 and saturates at 0xFFFF.
  - Adds input err_cnt_clr: synchronous clear; clear wins over a simultaneous increment.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- TX, frame 01 03 00 00 00 01 (last on 01) -> m stream 01 03 00 00 00 01 84 0A, m_last on 0A, crc_value 0x0A84, frame_done with ok = err = 0.
- RX, frame 01 03 00 00 00 01 84 0A -> 8 bytes passed through, m_last on 0A, frame_done with crc_ok = 1, crc_err = 0, crc_value 0x0000.
- RX, same frame with the last byte 0B -> crc_ok = 0, crc_err = 1. Back-to-back repeat of the correct frame -> crc_ok = 1, proving INIT re-seeds 0xFFFF.
- TX frame 01 03 with m_ready held low for 20 cycles on each byte -> no byte loss; crc_en exactly once per input byte; output 01 03 then CRC low/high.
- RX 2-byte frame, and a MAX_LEN+1 byte frame -> crc_err = 1. With CRC16_ERR_CNT_EN, err_cnt = 2; err_cnt_clr -> 0.
- rst_n pulsed low after byte 3 of a TX frame -> outputs immediately reset. The next frame 01 03 00 00 00 01 still yields 84 0A.

Source files
------------

// File: rtl/crc16_frame_ctrl.sv
// Frame sequencer around a bit-serial Modbus CRC-16 engine: TX appends the CRC low byte first, RX checks the residual.
// Optional build macro CRC16_ERR_CNT_EN adds a saturating error-frame counter (err_cnt, err_cnt_clr).
module crc16_frame_ctrl #(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_mode,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        crc_rst_n,
  output logic        crc_en,
  output logic [7:0]  crc_data,
  input  logic [15:0] crc_reg,
  input  logic        crc_ready,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic [15:0] crc_value
`ifdef CRC16_ERR_CNT_EN
  ,
  input  logic        err_cnt_clr,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [LEN_W-1:0] LP_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_GET, S_FEED, S_XFER, S_APP_LO, S_APP_HI, S_CHECK, S_DONE, S_DROP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_inc;
  logic             r_tx;
  logic             r_hold_last;
  logic [7:0]       r_hold;
  logic             r_mdone;
  logic             r_seen;
  logic             r_over;
  logic             r_ok;
  logic             r_err;
  logic [15:0]      r_crc_value;
  logic             w_s_hs;
  logic             w_m_hs;
  logic             w_rx_good;

  assign w_cnt_inc = r_cnt + LEN_W'(1);
  assign w_s_hs    = s_valid && s_ready;
  assign w_m_hs    = m_valid && m_ready;
  assign w_rx_good = (r_cnt >= LEN_W'(3)) && (crc_reg == 16'h0000);
  assign crc_value = r_crc_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = 8'h00;
    m_last     = 1'b0;
    crc_rst_n  = 1'b1;
    crc_en     = 1'b0;
    crc_data   = 8'h00;
    frame_done = 1'b0;
    crc_ok     = 1'b0;
    crc_err    = 1'b0;
    case (r_state)
      S_IDLE: if (s_valid) w_next = S_INIT;
      S_INIT: begin
        crc_rst_n = 1'b0;
        w_next    = S_GET;
      end
      S_GET: begin
        s_ready = 1'b1;
        if (s_valid) w_next = S_FEED;
      end
      S_FEED: begin
        crc_en   = 1'b1;
        crc_data = r_hold;
        w_next   = S_XFER;
      end
      // Byte accepted downstream and engine done, in either order; ready is stale on the first cycle.
      S_XFER: begin
        m_valid = !r_mdone;
        m_data  = r_hold;
        m_last  = r_hold_last && !r_tx;
        if ((r_mdone || m_ready) && r_seen && crc_ready) begin
          if (r_over)           w_next = S_DROP;
          else if (!r_hold_last) w_next = S_GET;
          else if (r_tx)        w_next = S_APP_LO;
          else                  w_next = S_CHECK;
        end
      end
      S_APP_LO: begin
        m_valid = 1'b1;
        m_data  = crc_reg[7:0];
        if (m_ready) w_next = S_APP_HI;
      end
      S_APP_HI: begin
        m_valid = 1'b1;
        m_data  = crc_reg[15:8];
        m_last  = 1'b1;
        if (m_ready) w_next = S_DONE;
      end
      S_CHECK: w_next = S_DONE;
      S_DONE: begin
        frame_done = 1'b1;
        crc_ok     = r_ok;
        crc_err    = r_err;
        w_next     = S_IDLE;
      end
      S_DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx        <= 1'b0;
      r_cnt       <= '0;
      r_hold_last <= 1'b0;
      r_mdone     <= 1'b0;
      r_seen      <= 1'b0;
      r_over      <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_crc_value <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: if (s_valid) r_tx <= tx_mode;
        S_INIT: begin
          r_cnt  <= '0;
          r_over <= 1'b0;
          r_ok   <= 1'b0;
          r_err  <= 1'b0;
        end
        S_GET: if (w_s_hs) begin
          r_hold_last <= s_last;
          r_cnt       <= w_cnt_inc;
          if ((w_cnt_inc == LP_MAX) && !s_last) r_over <= 1'b1;
        end
        S_FEED: begin
          r_mdone <= 1'b0;
          r_seen  <= 1'b0;
        end
        S_XFER: begin
          r_seen <= 1'b1;
          if (w_m_hs) r_mdone <= 1'b1;
        end
        S_CHECK: begin
          r_ok  <= w_rx_good;
          r_err <= !w_rx_good;
        end
        S_DROP: if (w_s_hs && s_last) r_err <= 1'b1;
        S_DONE: r_crc_value <= crc_reg;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_GET) && w_s_hs) r_hold <= s_data;
  end

`ifdef CRC16_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 16'h0000;
    end else if (err_cnt_clr) begin
      r_err_cnt <= 16'h0000;
    end else if ((r_state == S_DONE) && r_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
